// File: rtl/ulaplus_port_ctrl.sv
// ulaplus_port_ctrl: Z80 I/O decode for the ULAplus select/data ports and arbiter for the shared palette RAM address.
// Define ULAPLUS_READBACK_EN to add CPU read-back of the data port (extra FSM states, read synchroniser, cpu_oe).
module ulaplus_port_ctrl #(
  parameter logic [15:0] SEL_PORT    = 16'hBF3B,
  parameter logic [15:0] DATA_PORT   = 16'hFF3B,
  parameter int          SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] a,
  input  logic        iorq_n,
  input  logic        wr_n,
  input  logic        rd_n,
  input  logic [7:0]  cpu_din,
  output logic [7:0]  cpu_dout,
  output logic        cpu_oe,
  output logic [5:0]  pal_a,
  output logic [7:0]  pal_din,
  output logic        pal_we,
  input  logic [7:0]  pal_dout,
  input  logic [5:0]  vid_idx,
  output logic [7:0]  vid_color,
  output logic        ulaplus_on
);

`ifdef ULAPLUS_READBACK_EN
  typedef enum logic [2:0] {S_IDLE, S_WR_ADDR, S_WR_COMMIT, S_RD_ADDR, S_RD_CAPT} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_WR_ADDR, S_WR_COMMIT} state_t;
`endif

  state_t                 r_state, r_pend_st;
  logic                   r_pend_vld;
  logic [5:0]             r_pend_addr, r_op_addr;
  logic [7:0]             r_pend_data, r_op_data;
  logic [7:0]             r_reg_sel, r_vid_color;
  logic                   r_on;
  logic [15:0]            r_a_pipe [SYNC_STAGES];
  logic [7:0]             r_d_pipe [SYNC_STAGES];
  logic [SYNC_STAGES-1:0] r_wr_sync;
  logic                   r_wr_prev;
  logic                   w_wr_ev;
  logic [15:0]            w_ev_a;
  logic [7:0]             w_ev_d;
  logic [1:0]             w_grp;
  logic                   w_sel_wr, w_dat_wr, w_pal_wr, w_mode_wr;
  logic                   w_op_req, w_to_pend;
  state_t                 w_new_st;

  // Bus sample pipeline has the synchroniser's depth so a/cpu_din line up with the strobe edge.
  always_ff @(posedge clk) begin
    r_a_pipe[0] <= a;
    r_d_pipe[0] <= cpu_din;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      r_a_pipe[i] <= r_a_pipe[i-1];
      r_d_pipe[i] <= r_d_pipe[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_sync <= '0;
      r_wr_prev <= 1'b0;
    end else begin
      r_wr_sync <= {r_wr_sync[SYNC_STAGES-2:0], ~iorq_n & ~wr_n};
      r_wr_prev <= r_wr_sync[SYNC_STAGES-1];
    end
  end

  assign w_wr_ev   = r_wr_sync[SYNC_STAGES-1] & ~r_wr_prev;
  assign w_ev_a    = r_a_pipe[SYNC_STAGES-1];
  assign w_ev_d    = r_d_pipe[SYNC_STAGES-1];
  assign w_grp     = r_reg_sel[7:6];
  assign w_sel_wr  = w_wr_ev & (w_ev_a == SEL_PORT);
  assign w_dat_wr  = w_wr_ev & (w_ev_a == DATA_PORT);
  assign w_pal_wr  = w_dat_wr & (w_grp == 2'b00);
  assign w_mode_wr = w_dat_wr & (w_grp == 2'b01);

`ifdef ULAPLUS_READBACK_EN
  logic [SYNC_STAGES-1:0] r_rd_sync;
  logic                   r_rd_prev;
  logic [7:0]             r_cpu_dout;
  logic                   w_rd_ev, w_dat_rd, w_pal_rd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_sync <= '0;
      r_rd_prev <= 1'b0;
    end else begin
      r_rd_sync <= {r_rd_sync[SYNC_STAGES-2:0], ~iorq_n & ~rd_n};
      r_rd_prev <= r_rd_sync[SYNC_STAGES-1];
    end
  end

  assign w_rd_ev  = r_rd_sync[SYNC_STAGES-1] & ~r_rd_prev & ~w_wr_ev;
  assign w_dat_rd = w_rd_ev & (w_ev_a == DATA_PORT);
  assign w_pal_rd = w_dat_rd & (w_grp == 2'b00);
  assign w_op_req = w_pal_wr | w_pal_rd;
  assign w_new_st = w_pal_rd ? S_RD_ADDR : S_WR_ADDR;
  assign cpu_oe   = ~iorq_n & ~rd_n & (a == DATA_PORT);
  assign cpu_dout = r_cpu_dout;

  // Mode and unmapped groups answer immediately; palette reads wait for RD_CAPT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_cpu_dout <= 8'h00;
    else if (r_state == S_RD_CAPT)
      r_cpu_dout <= pal_dout;
    else if (w_dat_rd && (w_grp != 2'b00))
      r_cpu_dout <= (w_grp == 2'b01) ? {7'b0, r_on} : 8'hFF;
  end
`else
  logic w_unused_rd;
  assign w_unused_rd = rd_n;
  assign w_op_req    = w_pal_wr;
  assign w_new_st    = S_WR_ADDR;
  assign cpu_oe      = 1'b0;
  assign cpu_dout    = 8'hFF;
`endif

  // A request goes to the pending slot if the FSM is busy, or if IDLE is draining the slot this cycle.
  assign w_to_pend = w_op_req & ((r_state == S_IDLE) ? r_pend_vld : ~r_pend_vld);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_pend_st   <= S_IDLE;
      r_pend_vld  <= 1'b0;
      r_pend_addr <= 6'd0;
      r_pend_data <= 8'h00;
      r_op_addr   <= 6'd0;
      r_op_data   <= 8'h00;
      r_reg_sel   <= 8'h00;
      r_on        <= 1'b0;
      r_vid_color <= 8'h00;
    end else begin
      if (w_sel_wr)  r_reg_sel <= w_ev_d;
      if (w_mode_wr) r_on      <= w_ev_d[0];

      if (w_to_pend) begin
        r_pend_vld  <= 1'b1;
        r_pend_st   <= w_new_st;
        r_pend_addr <= r_reg_sel[5:0];
        r_pend_data <= w_ev_d;
      end else if (r_state == S_IDLE) begin
        r_pend_vld  <= 1'b0;
      end

      if (r_state == S_IDLE) begin
        r_vid_color <= pal_dout;
        if (r_pend_vld) begin
          r_state   <= r_pend_st;
          r_op_addr <= r_pend_addr;
          r_op_data <= r_pend_data;
        end else if (w_op_req) begin
          r_state   <= w_new_st;
          r_op_addr <= r_reg_sel[5:0];
          r_op_data <= w_ev_d;
        end
      end else begin
        case (r_state)
          S_WR_ADDR: r_state <= S_WR_COMMIT;
`ifdef ULAPLUS_READBACK_EN
          S_RD_ADDR: r_state <= S_RD_CAPT;
`endif
          default:   r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign pal_a      = (r_state == S_IDLE) ? vid_idx : r_op_addr;
  assign pal_din    = r_op_data;
  assign pal_we     = (r_state == S_WR_COMMIT);
  assign vid_color  = r_vid_color;
  assign ulaplus_on = r_on;

endmodule

// File: tb/tb_ulaplus_port_ctrl.sv
// tb_ulaplus_port_ctrl: directed and randomized Z80 I/O cycles against a port-level model of the ULAplus controller.
// Works with or without ULAPLUS_READBACK_EN defined.
module tb_ulaplus_port_ctrl;
  localparam logic [15:0] SEL = 16'hBF3B;
  localparam logic [15:0] DAT = 16'hFF3B;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] a = 16'h0000;
  logic        iorq_n = 1'b1, wr_n = 1'b1, rd_n = 1'b1;
  logic [7:0]  cpu_din = 8'h00;
  logic [7:0]  cpu_dout;
  logic        cpu_oe;
  logic [5:0]  pal_a;
  logic [7:0]  pal_din;
  logic        pal_we;
  logic [7:0]  pal_dout;
  logic [5:0]  vid_idx = 6'd0;
  logic [7:0]  vid_color;
  logic        ulaplus_on;

  logic [7:0]  ram [64];
  logic        pre_en = 1'b0;
  logic [5:0]  pre_a = 6'd0;
  logic [7:0]  pre_d = 8'h00;

  logic [7:0]  m_ram [64];
  logic [7:0]  m_sel;
  logic        m_on;
  logic [13:0] exp_q [$];
  int          n_we, n_busy;
  int          n_chk = 0, n_fail = 0;

  ulaplus_port_ctrl dut (
    .clk(clk), .rst_n(rst_n), .a(a), .iorq_n(iorq_n), .wr_n(wr_n), .rd_n(rd_n),
    .cpu_din(cpu_din), .cpu_dout(cpu_dout), .cpu_oe(cpu_oe),
    .pal_a(pal_a), .pal_din(pal_din), .pal_we(pal_we), .pal_dout(pal_dout),
    .vid_idx(vid_idx), .vid_color(vid_color), .ulaplus_on(ulaplus_on)
  );

  always #5 clk = ~clk;

  // Palette RAM: async read, sync write; the bench preloads it through the same port.
  assign pal_dout = ram[pal_a];
  always @(posedge clk) begin
    if (pal_we)      ram[pal_a] <= pal_din;
    else if (pre_en) ram[pre_a] <= pre_d;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (pal_a != vid_idx) n_busy++;
    if (pal_we) begin
      n_we++;
      check_eq("we_expected", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) check_eq("pal_write", {pal_a, pal_din}, exp_q.pop_front());
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [5:0] idx, input logic [7:0] val);
    pre_a = idx; pre_d = val; pre_en = 1'b1;
    tick(1);
    pre_en = 1'b0;
    m_ram[idx] = val;
  endtask

  // Model effect of one CPU OUT, applied when the cycle is issued.
  task automatic model_out(input logic [15:0] addr, input logic [7:0] data, output int we_exp);
    we_exp = 0;
    if (addr == SEL) m_sel = data;
    else if (addr == DAT) begin
      if (m_sel[7:6] == 2'b00) begin
        exp_q.push_back({m_sel[5:0], data});
        m_ram[m_sel[5:0]] = data;
        we_exp = 1;
      end else if (m_sel[7:6] == 2'b01) m_on = data[0];
    end
  endtask

  task automatic io_write(input logic [15:0] addr, input logic [7:0] data);
    int we_exp;
    model_out(addr, data, we_exp);
    n_we = 0;
    a = addr; cpu_din = data; iorq_n = 1'b0; wr_n = 1'b0;
    tick(3);
    iorq_n = 1'b1; wr_n = 1'b1; a = 16'($urandom); cpu_din = 8'($urandom);
    tick(8);
    check_eq("mode_bit", ulaplus_on, m_on);
    check_eq("we_count", n_we, we_exp);
  endtask

  task automatic io_read(input logic [15:0] addr);
    logic       exp_oe;
    logic [7:0] exp_dout;
`ifdef ULAPLUS_READBACK_EN
    exp_oe = (addr == DAT);
    case (m_sel[7:6])
      2'b00:   exp_dout = m_ram[m_sel[5:0]];
      2'b01:   exp_dout = {7'b0, m_on};
      default: exp_dout = 8'hFF;
    endcase
`else
    exp_oe = 1'b0;
    exp_dout = 8'hFF;
`endif
    n_we = 0;
    a = addr; iorq_n = 1'b0; rd_n = 1'b0;
    tick(8);
    @(negedge clk);
    check_eq("oe_during_in", cpu_oe, exp_oe);
`ifdef ULAPLUS_READBACK_EN
    if (addr == DAT) check_eq("cpu_dout", cpu_dout, exp_dout);
`else
    check_eq("cpu_dout", cpu_dout, exp_dout);
`endif
    @(posedge clk); #1;
    iorq_n = 1'b1; rd_n = 1'b1;
    tick(1);
    check_eq("oe_after_in", cpu_oe, 1'b0);
    tick(5);
    check_eq("we_on_read", n_we, 0);
  endtask

  task automatic vid_check(input logic [5:0] idx);
    vid_idx = idx;
    @(posedge clk);
    @(negedge clk);
    check_eq("vid_color", vid_color, m_ram[idx]);
    @(posedge clk); #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] old12;
    bit         found;
    int         r;
    m_sel = 8'h00;
    m_on  = 1'b0;

    // Reset values and first video lookup
    rst_n = 1'b0;
    tick(1);
    for (int i = 0; i < 64; i++) preload(6'(i), 8'($urandom));
    vid_idx = 6'd5;
    preload(6'd5, 8'hE3);
    tick(2);
    check_eq("rst_vid_color", vid_color, 8'h00);
    check_eq("rst_ulaplus_on", ulaplus_on, 1'b0);
    check_eq("rst_pal_we", pal_we, 1'b0);
    check_eq("rst_cpu_oe", cpu_oe, 1'b0);
`ifdef ULAPLUS_READBACK_EN
    check_eq("rst_cpu_dout", cpu_dout, 8'h00);
`else
    check_eq("rst_cpu_dout", cpu_dout, 8'hFF);
`endif
    check_eq("rst_pal_a", pal_a, 6'd5);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_eq("vid_after_rst", vid_color, 8'hE3);
    tick(1);

    // Palette write with video parked elsewhere
    vid_idx = 6'd9;
    io_write(SEL, 8'h05);
    n_busy = 0;
    io_write(DAT, 8'h1C);
    check_eq("busy_cycles", n_busy, 2);
    vid_check(6'd5);

    // Mode register
    io_write(SEL, 8'h40);
    io_write(DAT, 8'h01);
    io_write(DAT, 8'h00);

    // Read-back paths
    preload(6'd10, 8'hA5);
    io_write(SEL, 8'h0A);
    io_read(DAT);
    io_read(SEL);
    io_write(SEL, 8'h40);
    io_write(DAT, 8'h01);
    io_read(DAT);
    io_write(SEL, 8'h80);
    io_read(DAT);

    // Long write strobe gives one event
    io_write(SEL, 8'h07);
    exp_q.push_back({6'd7, 8'h3C});
    m_ram[7] = 8'h3C;
    n_we = 0;
    a = DAT; cpu_din = 8'h3C; iorq_n = 1'b0; wr_n = 1'b0;
    tick(20);
    iorq_n = 1'b1; wr_n = 1'b1;
    tick(8);
    check_eq("long_strobe_we", n_we, 1);

    // Back-to-back events: second goes through the pending slot
    io_write(SEL, 8'h21);
    exp_q.push_back({6'h21, 8'h11});
    exp_q.push_back({6'h21, 8'h22});
    m_ram[6'h21] = 8'h22;
    n_we = 0;
    a = DAT; cpu_din = 8'h11; iorq_n = 1'b0; wr_n = 1'b0;
    tick(1);
    wr_n = 1'b1; cpu_din = 8'h22;
    tick(1);
    wr_n = 1'b0;
    tick(1);
    iorq_n = 1'b1; wr_n = 1'b1;
    tick(10);
    check_eq("b2b_we", n_we, 2);
    vid_check(6'h21);

    // Reset while the write is in WR_ADDR
    io_write(SEL, 8'h40);
    io_write(DAT, 8'h01);
    io_write(SEL, 8'h0C);
    vid_idx = 6'h30;
    old12 = m_ram[12];
    n_we = 0;
    found = 1'b0;
    a = DAT; cpu_din = 8'h5A; iorq_n = 1'b0; wr_n = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (pal_a == 6'h0C) begin
        found = 1'b1;
        break;
      end
    end
    check_eq("wr_addr_reached", found, 1'b1);
    rst_n = 1'b0;
    #1;
    check_eq("rst_mid_we", pal_we, 1'b0);
    m_sel = 8'h00;
    m_on  = 1'b0;
    @(posedge clk); #1;
    iorq_n = 1'b1; wr_n = 1'b1;
    tick(3);
    check_eq("rst_mid_on", ulaplus_on, 1'b0);
    rst_n = 1'b1;
    tick(4);
    check_eq("rst_mid_no_we", n_we, 0);
    check_eq("rst_mid_ram", ram[12], old12);
    io_write(DAT, 8'h77);
    vid_check(6'd0);

    // Randomized bus traffic
    for (int k = 0; k < 60; k++) begin
      r = $urandom_range(0, 9);
      if (r < 3)      io_write(SEL, 8'($urandom));
      else if (r < 6) io_write(($urandom_range(0, 7) == 0) ? 16'h7F3B : DAT, 8'($urandom));
      else if (r < 8) io_read(($urandom_range(0, 3) == 0) ? SEL : DAT);
      else            vid_check(6'($urandom_range(0, 63)));
    end

    tick(4);
    check_eq("queue_drained", exp_q.size(), 0);
    for (int i = 0; i < 64; i++) check_eq("ram_final", ram[i], m_ram[i]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
